// File: rtl/rto_ctrl_pkg.sv
// Shared types and defaults for the RTO run controller and its error trackers.
package rto_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StHalt  = 2'd3
  } rto_state_e;

  localparam int unsigned FlushCyclesDef = 4;
  localparam int unsigned ErrCntWDef     = 16;

endpackage

// File: rtl/rto_err_tracker.sv
// Sticky error flag plus saturating error counter for one RTO core error source.
module rto_err_tracker
  import rto_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = ErrCntWDef
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             err,
  input  logic             clear,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             sticky_q;
  logic [CNT_W-1:0] count_q;

  // A new error in the same cycle as a clear survives it: flag stays set, count restarts at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (err) begin
        sticky_q <= 1'b1;
      end else if (clear) begin
        sticky_q <= 1'b0;
      end

      if (err) begin
        if (clear) begin
          count_q <= CNT_W'(1);
        end else if (count_q != CntMax) begin
          count_q <= count_q + CNT_W'(1);
        end
      end else if (clear) begin
        count_q <= '0;
      end
    end
  end

  assign sticky = sticky_q;
  assign count  = count_q;

endmodule

// File: rtl/rto_run_controller.sv
// Run/flush/halt sequencer driving the RTO core timestamp counter, auto_start and flush.
module rto_run_controller
  import rto_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDef,
  parameter int unsigned ERR_CNT_W    = ErrCntWDef
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 flush_req,
  input  logic                 halt_on_error,
  input  logic                 counter_load,
  input  logic [63:0]          counter_load_value,
  input  logic                 err_clear,
  input  logic                 core_empty,
  input  logic                 core_timestamp_error,
  input  logic                 core_overflow_error,
  output logic [63:0]          counter,
  output logic                 auto_start,
  output logic                 flush,
  output logic [1:0]           state,
  output logic                 done,
  output logic                 ts_err_sticky,
  output logic                 ovf_err_sticky,
  output logic [ERR_CNT_W-1:0] ts_err_count,
  output logic [ERR_CNT_W-1:0] ovf_err_count
);

  localparam int unsigned     FcW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0]  LastFlush = FcW'(FLUSH_CYCLES - 1);

  rto_state_e     state_q;
  logic [63:0]    counter_q;
  logic [FcW-1:0] flush_cnt_q;
  logic           auto_start_q;
  logic           flush_q;
  logic           done_q;
  logic           core_err;

  assign core_err = core_timestamp_error | core_overflow_error;

  // The counter advances only on RUN edges that stay in RUN, so leaving RUN
  // (stop, halt) leaves the last value the core saw untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      flush_cnt_q  <= '0;
      auto_start_q <= 1'b0;
      flush_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush_req) begin
            state_q     <= StFlush;
            flush_q     <= 1'b1;
            counter_q   <= '0;
            flush_cnt_q <= '0;
          end else if (start) begin
            state_q      <= StRun;
            auto_start_q <= 1'b1;
          end else if (counter_load) begin
            counter_q <= counter_load_value;
          end
        end
        StRun: begin
          if (flush_req) begin
            state_q      <= StFlush;
            auto_start_q <= 1'b0;
            flush_q      <= 1'b1;
            counter_q    <= '0;
            flush_cnt_q  <= '0;
          end else if (halt_on_error && core_err) begin
            state_q      <= StHalt;
            auto_start_q <= 1'b0;
          end else if (stop) begin
            state_q      <= StIdle;
            auto_start_q <= 1'b0;
            done_q       <= core_empty;
          end else begin
            counter_q <= counter_q + 64'd1;
          end
        end
        StFlush: begin
          if (flush_cnt_q == LastFlush) begin
            state_q     <= StIdle;
            flush_q     <= 1'b0;
            flush_cnt_q <= '0;
            done_q      <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + FcW'(1);
          end
        end
        StHalt: begin
          if (flush_req) begin
            state_q     <= StFlush;
            flush_q     <= 1'b1;
            counter_q   <= '0;
            flush_cnt_q <= '0;
          end else if (err_clear) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign counter    = counter_q;
  assign auto_start = auto_start_q;
  assign flush      = flush_q;
  assign state      = state_q;
  assign done       = done_q;

  rto_err_tracker #(
    .CNT_W (ERR_CNT_W)
  ) u_ts_err (
    .clk    (clk),
    .reset  (reset),
    .err    (core_timestamp_error),
    .clear  (err_clear),
    .sticky (ts_err_sticky),
    .count  (ts_err_count)
  );

  rto_err_tracker #(
    .CNT_W (ERR_CNT_W)
  ) u_ovf_err (
    .clk    (clk),
    .reset  (reset),
    .err    (core_overflow_error),
    .clear  (err_clear),
    .sticky (ovf_err_sticky),
    .count  (ovf_err_count)
  );

endmodule
